// File: rtl/ifm_fetch_ctrl.sv
// ifm_fetch_ctrl: walks an IFM_W x IFM_H int8 map in SRAM, one kernel row per pass, and feeds the 3-tap shift buffer.
// Latency: read issued at t -> ifm_read/ifm_input at t+1 -> win_valid (with kr/row/col tags) at t+2.
// Backpressure: stall=1 blocks new SRAM reads and freezes the walk; reads already in flight still drain.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, ifm_base       job start (accepted only in IDLE) and map base address
//   stall                 downstream backpressure
//   mem_rd_en, mem_addr   SRAM read strobe/address; mem_rdata returns one cycle later
//   ifm_input, ifm_read   pixel and shift enable to the tap buffer
//   win_valid, win_kr,
//   win_row, win_col      taps hold a full 3-pixel row segment, with its tags
//   busy, done            job in progress / one-cycle completion pulse
//
// Build option: define IFM_FETCH_PAD_EN for 1-pixel zero padding (IFM_H output rows,
// IFM_W+2 slots per pass, out-of-map slots shift in zeros without touching SRAM).

module ifm_fetch_ctrl #(
    parameter int IFM_W  = 32,
    parameter int IFM_H  = 32,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic              stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ifm_input,
    output logic              ifm_read,
    output logic              win_valid,
    output logic [1:0]        win_kr,
    output logic [CNT_W-1:0]  win_row,
    output logic [CNT_W-1:0]  win_col,
    output logic              busy,
    output logic              done
);

`ifdef IFM_FETCH_PAD_EN
    // Slot counter c runs 0..IFM_W+1 and stands for column c-1.
    localparam int C_LAST = IFM_W + 1;
    localparam int R_LAST = IFM_H - 1;
    // End of a pass sits one past the row end; next pass starts one before the next row.
    localparam logic [ADDR_W-1:0] KR_STEP  = '1;
    localparam logic [ADDR_W-1:0] ROW_BACK = ADDR_W'(2 * IFM_W + 1);
    localparam logic [ADDR_W-1:0] START_OFS = ADDR_W'(IFM_W + 1);
`else
    localparam int C_LAST = IFM_W - 1;
    localparam int R_LAST = IFM_H - 3;
    // Rows are contiguous, so moving to the next kernel row is a plain +1;
    // after kr=2 the walk rewinds two rows to start output row r+1.
    localparam logic [ADDR_W-1:0] KR_STEP  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_BACK = ADDR_W'(2 * IFM_W - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    r_q, r_d;
    logic [1:0]          kr_q, kr_d;
    logic [CNT_W-1:0]    c_q, c_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    // Stage 1: slot whose pixel is on ifm_input this cycle.
    logic                s1_vld_q, s1_vld_d;
    logic [1:0]          s1_kr_q, s1_kr_d;
    logic [CNT_W-1:0]    s1_row_q, s1_row_d;
    logic [CNT_W-1:0]    s1_c_q, s1_c_d;

    // Stage 2: window flag and tags.
    logic                wv_q, wv_d;
    logic [1:0]          wkr_q, wkr_d;
    logic [CNT_W-1:0]    wrow_q, wrow_d;
    logic [CNT_W-1:0]    wcol_q, wcol_d;

    logic                issue;
    logic                last_slot;

    assign issue     = (state_q == S_FETCH) && !stall;
    assign last_slot = (r_q == CNT_W'(R_LAST)) && (kr_q == 2'd2) && (c_q == CNT_W'(C_LAST));

`ifdef IFM_FETCH_PAD_EN
    logic s1_mem_q, s1_mem_d;
    logic row_ok, col_ok;

    // Input row r-1+kr falls outside the map only on the first pass of row 0
    // and the last pass of the last row; columns 0 and C_LAST are the side pads.
    assign row_ok    = !(((r_q == '0) && (kr_q == 2'd0)) ||
                         ((r_q == CNT_W'(R_LAST)) && (kr_q == 2'd2)));
    assign col_ok    = (c_q != '0) && (c_q != CNT_W'(C_LAST));
    assign mem_rd_en = issue && row_ok && col_ok;
    assign ifm_input = s1_mem_q ? mem_rdata : '0;
`else
    assign mem_rd_en = issue;
    assign ifm_input = s1_vld_q ? mem_rdata : '0;
`endif

    assign mem_addr  = mem_rd_en ? addr_q : '0;
    assign ifm_read  = s1_vld_q;
    assign win_valid = wv_q;
    assign win_kr    = wkr_q;
    assign win_row   = wrow_q;
    assign win_col   = wcol_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        kr_d    = kr_q;
        c_d     = c_q;
        addr_d  = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    r_d     = '0;
                    kr_d    = '0;
                    c_d     = '0;
`ifdef IFM_FETCH_PAD_EN
                    addr_d  = ifm_base - START_OFS;
`else
                    addr_d  = ifm_base;
`endif
                end
            end
            S_FETCH: begin
                if (!stall) begin
                    if (last_slot) begin
                        state_d = S_DRAIN;
                    end else if (c_q == CNT_W'(C_LAST)) begin
                        c_d = '0;
                        if (kr_q == 2'd2) begin
                            kr_d   = '0;
                            r_d    = r_q + 1'b1;
                            addr_d = addr_q - ROW_BACK;
                        end else begin
                            kr_d   = kr_q + 1'b1;
                            addr_d = addr_q + KR_STEP;
                        end
                    end else begin
                        c_d    = c_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s1_vld_d = issue;
        s1_kr_d  = kr_q;
        s1_row_d = r_q;
        s1_c_d   = c_q;
`ifdef IFM_FETCH_PAD_EN
        s1_mem_d = mem_rd_en;
`endif
        // The first two slots of a pass leave stale taps from the previous pass.
        wv_d   = s1_vld_q && (s1_c_q >= CNT_W'(2));
        wkr_d  = '0;
        wrow_d = '0;
        wcol_d = '0;
        if (wv_d) begin
            wkr_d  = s1_kr_q;
            wrow_d = s1_row_q;
            wcol_d = s1_c_q - CNT_W'(2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            kr_q     <= '0;
            c_q      <= '0;
            addr_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_kr_q  <= '0;
            s1_row_q <= '0;
            s1_c_q   <= '0;
            wv_q     <= 1'b0;
            wkr_q    <= '0;
            wrow_q   <= '0;
            wcol_q   <= '0;
`ifdef IFM_FETCH_PAD_EN
            s1_mem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            kr_q     <= kr_d;
            c_q      <= c_d;
            addr_q   <= addr_d;
            s1_vld_q <= s1_vld_d;
            s1_kr_q  <= s1_kr_d;
            s1_row_q <= s1_row_d;
            s1_c_q   <= s1_c_d;
            wv_q     <= wv_d;
            wkr_q    <= wkr_d;
            wrow_q   <= wrow_d;
            wcol_q   <= wcol_d;
`ifdef IFM_FETCH_PAD_EN
            s1_mem_q <= s1_mem_d;
`endif
        end
    end

endmodule
